// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Iterative shift-add multiply and restoring divide, one bit per cycle, with sign fix-up at the end.
module muldiv_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int FUNCT_WIDTH = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [FUNCT_WIDTH-1:0] i_Function_code,
  input  logic [DATA_WIDTH-1:0]  i_operand_a,
  input  logic [DATA_WIDTH-1:0]  i_operand_b,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_stall,
  output logic [DATA_WIDTH-1:0]  o_hi,
  output logic [DATA_WIDTH-1:0]  o_lo,
  output logic [DATA_WIDTH-1:0]  o_mf_data
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  localparam logic [FUNCT_WIDTH-1:0] F_MFHI  = FUNCT_WIDTH'(6'b010000);
  localparam logic [FUNCT_WIDTH-1:0] F_MTHI  = FUNCT_WIDTH'(6'b010001);
  localparam logic [FUNCT_WIDTH-1:0] F_MFLO  = FUNCT_WIDTH'(6'b010010);
  localparam logic [FUNCT_WIDTH-1:0] F_MTLO  = FUNCT_WIDTH'(6'b010011);
  localparam logic [FUNCT_WIDTH-1:0] F_MULT  = FUNCT_WIDTH'(6'b011000);
  localparam logic [FUNCT_WIDTH-1:0] F_MULTU = FUNCT_WIDTH'(6'b011001);
  localparam logic [FUNCT_WIDTH-1:0] F_DIV   = FUNCT_WIDTH'(6'b011010);
  localparam logic [FUNCT_WIDTH-1:0] F_DIVU  = FUNCT_WIDTH'(6'b011011);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [2*DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0]   r_opnd;
  logic [DATA_WIDTH-1:0]   r_hi;
  logic [DATA_WIDTH-1:0]   r_lo;
  logic                    r_is_div;
  logic                    r_sign_a;
  logic                    r_sign_b;
  logic                    r_done;

  // Function-code decode
  logic w_is_mul, w_is_div, w_is_signed, w_is_md_op, w_is_hilo_op;
  assign w_is_mul     = (i_Function_code == F_MULT) || (i_Function_code == F_MULTU);
  assign w_is_div     = (i_Function_code == F_DIV)  || (i_Function_code == F_DIVU);
  assign w_is_signed  = (i_Function_code == F_MULT) || (i_Function_code == F_DIV);
  assign w_is_md_op   = w_is_mul || w_is_div;
  assign w_is_hilo_op = w_is_md_op || (i_Function_code == F_MFHI) || (i_Function_code == F_MFLO)
                        || (i_Function_code == F_MTHI) || (i_Function_code == F_MTLO);

  // Signed ops iterate on magnitudes; signs are re-applied in FIX
  logic                  w_neg_a, w_neg_b;
  logic [DATA_WIDTH-1:0] w_mag_a, w_mag_b;
  assign w_neg_a = w_is_signed & i_operand_a[DATA_WIDTH-1];
  assign w_neg_b = w_is_signed & i_operand_b[DATA_WIDTH-1];
  assign w_mag_a = w_neg_a ? -i_operand_a : i_operand_a;
  assign w_mag_b = w_neg_b ? -i_operand_b : i_operand_b;

  // Multiply step: {partial product, remaining multiplier bits} shifted right each cycle
  logic [DATA_WIDTH:0]     w_mul_sum;
  logic [2*DATA_WIDTH-1:0] w_mul_step;
  assign w_mul_sum  = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, r_opnd};
  assign w_mul_step = r_acc[0] ? {w_mul_sum, r_acc[DATA_WIDTH-1:1]}
                               : {1'b0, r_acc[2*DATA_WIDTH-1:1]};

  // Divide step: {remainder, dividend/quotient} shifted left, quotient bit enters at LSB
  logic [DATA_WIDTH:0]     w_div_shift, w_div_diff;
  logic                    w_div_ge;
  logic [DATA_WIDTH-1:0]   w_div_rem;
  logic [2*DATA_WIDTH-1:0] w_div_step;
  assign w_div_shift = r_acc[2*DATA_WIDTH-1:DATA_WIDTH-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_rem   = w_div_ge ? w_div_diff[DATA_WIDTH-1:0] : w_div_shift[DATA_WIDTH-1:0];
  assign w_div_step  = {w_div_rem, r_acc[DATA_WIDTH-2:0], w_div_ge};

  // Sign fix-up; a zero divisor leaves the magnitude of the dividend as remainder
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0]   w_quot, w_rem, w_fix_lo, w_fix_hi;
  assign w_quot   = r_acc[DATA_WIDTH-1:0];
  assign w_rem    = r_acc[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_prod   = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
  assign w_fix_lo = (r_opnd == '0) ? '1 : ((r_sign_a ^ r_sign_b) ? -w_quot : w_quot);
  assign w_fix_hi = r_sign_a ? -w_rem : w_rem;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (i_start && w_is_md_op) w_state_nxt = ST_RUN;
      ST_RUN:  if (r_cnt == '0)           w_state_nxt = ST_FIX;
      ST_FIX:                             w_state_nxt = ST_IDLE;
      default:                            w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_start && w_is_md_op) begin
            r_is_div <= w_is_div;
            r_sign_a <= w_neg_a;
            r_sign_b <= w_neg_b;
            r_cnt    <= CNT_W'(DATA_WIDTH - 1);
            r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
            r_acc    <= {{DATA_WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
          end else if (i_start && (i_Function_code == F_MTHI)) begin
            r_hi <= i_operand_a;
          end else if (i_start && (i_Function_code == F_MTLO)) begin
            r_lo <= i_operand_a;
          end
        end
        ST_RUN: begin
          r_acc <= r_is_div ? w_div_step : w_mul_step;
          r_cnt <= r_cnt - 1'b1;
        end
        ST_FIX: begin
          if (r_is_div) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy    = (r_state != ST_IDLE);
  assign o_done    = r_done;
  assign o_hi      = r_hi;
  assign o_lo      = r_lo;
  assign o_mf_data = (i_Function_code == F_MFHI) ? r_hi : r_lo;
  assign o_stall   = i_start & o_busy & w_is_hilo_op;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO pushed at issue, popped and compared on o_done.
module tb_muldiv_unit;
  localparam int W = 32;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   funct = '0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, stall;
  logic [W-1:0] hi, lo, mf_data;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e_pop;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  muldiv_unit #(.DATA_WIDTH(W), .FUNCT_WIDTH(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_Function_code(funct),
    .i_operand_a(a), .i_operand_b(b), .o_busy(busy), .o_done(done), .o_stall(stall),
    .o_hi(hi), .o_lo(lo), .o_mf_data(mf_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: architectural result {HI, LO} from plain integer arithmetic
  function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] x,
                                            input logic [31:0] y);
    int          sx, sy;
    longint      sp;
    logic [63:0] r;
    sx = $signed(x);
    sy = $signed(y);
    r  = '0;
    case (f)
      F_MULT: begin
        sp = longint'(sx) * longint'(sy);
        r  = sp;
      end
      F_MULTU: r = {32'b0, x} * {32'b0, y};
      F_DIV: begin
        if (y == 0)                                  r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else                                         r = {32'(sx % sy), 32'(sx / sy)};
      end
      F_DIVU: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else        r = {x % y, x / y};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Monitor: every o_done pulse retires the oldest expected result
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {63'b0, done}, 64'd0);
      end else begin
        e_pop = exp_q.pop_front();
        check("hi_lo", {hi, lo}, e_pop);
        m_hi = e_pop[63:32];
        m_lo = e_pop[31:0];
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy) check("idle_timeout", {63'b0, busy}, 64'd0);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    wait_idle();
    start = 1'b1;
    funct = f;
    a     = x;
    b     = y;
    if (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU)
      exp_q.push_back(ref_model(f, x, y));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          busy_cnt, done_at, done_cnt;
    logic        got;
    logic [31:0] old_lo, new_lo, x, y;
    logic [63:0] tmp;
    logic [5:0]  f;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  {63'b0, busy},  64'd0);
    check("rst_done",  {63'b0, done},  64'd0);
    check("rst_stall", {63'b0, stall}, 64'd0);
    check("rst_hilo",  {hi, lo},       64'd0);
    check("rst_mf",    {32'b0, mf_data}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MULTU max x max with latency and busy window
    do_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    busy_cnt = 0; done_at = -1; done_cnt = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_at = j;
        done_cnt++;
      end
    end
    check("multu_busy_cycles", 64'(busy_cnt), 64'd33);
    check("multu_done_cycle",  64'(done_at),  64'd33);
    check("multu_done_pulses", 64'(done_cnt), 64'd1);
    @(posedge clk); #1;

    // Signed multiply then back-to-back divide in the done cycle
    do_op(F_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_idle();
    check("b2b_in_done_cycle", {63'b0, done}, 64'd1);
    do_op(F_DIV, 32'hFFFF_FFF9, 32'd2);
    do_op(F_DIVU, 32'd7, 32'd2);
    do_op(F_DIVU, 32'd5, 32'd0);
    do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(F_DIV, 32'hFFFF_FFF6, 32'd0);
    drain();

    // MFLO held while busy: stalls, old LO visible, MULT start ignored
    old_lo = m_lo;
    x = $urandom; y = $urandom;
    tmp = ref_model(F_MULTU, x, y);
    new_lo = tmp[31:0];
    do_op(F_MULTU, x, y);
    start = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      funct = (k == 3 || k == 4) ? F_MULT : F_MFLO;
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      if (done) begin
        check("mflo_done_stall", {63'b0, stall}, 64'd0);
        check("mflo_done_data", {32'b0, mf_data}, {32'b0, new_lo});
        got = 1'b1;
      end else begin
        check("busy_stall", {63'b0, stall}, 64'd1);
        if (funct == F_MFLO) check("busy_old_lo", {32'b0, mf_data}, {32'b0, old_lo});
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (!got) check("mflo_done_seen", {63'b0, done}, 64'd1);
    drain();

    // MTHI then MFHI
    start = 1'b1;
    funct = F_MTHI;
    a = 32'h1234_5678;
    @(posedge clk); #1;
    m_hi = 32'h1234_5678;
    funct = F_MFHI;
    @(negedge clk);
    check("mthi_mfhi", {32'b0, mf_data}, {32'b0, m_hi});
    check("mthi_busy", {63'b0, busy}, 64'd0);
    check("mthi_done", {63'b0, done}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("mthi_lo_kept", {32'b0, lo}, {32'b0, m_lo});

    // Randomized mul/div stream, issued back-to-back
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       f = F_MULT;
        1:       f = F_MULTU;
        2:       f = F_DIV;
        default: f = F_DIVU;
      endcase
      do_op(f, pick_operand(), pick_operand());
    end
    drain();

    // Asynchronous reset in the middle of a MULT
    do_op(F_MULT, $urandom, $urandom);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    m_hi = '0;
    m_lo = '0;
    #1;
    check("arst_busy",  {63'b0, busy},  64'd0);
    check("arst_done",  {63'b0, done},  64'd0);
    check("arst_hilo",  {hi, lo},       64'd0);
    check("arst_mf",    {32'b0, mf_data}, 64'd0);
    check("arst_stall", {63'b0, stall}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(F_DIVU, 32'd100, 32'd7);
    drain();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the EX stage and owns the architectural HI/LO registers. It decodes MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO from the R-type function code. It runs iterative shift-add multiplication and restoring division over `DATA_WIDTH` cycles, and raises `o_stall` so the hazard unit freezes the front of the pipeline until the result is ready.

## Interface
- `DATA_WIDTH`, 32: operand, HI and LO width; must be ≥ 4.
- `FUNCT_WIDTH`, 6: function-code width.
- `i_clk`  in  1  clock; all state changes on rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  EX stage holds a valid R-type instruction this cycle.
- `i_Function_code`  in  FUNCT_WIDTH  instruction funct field.
- `i_operand_a`  in  DATA_WIDTH  rs value (multiplicand or dividend).
- `i_operand_b`  in  DATA_WIDTH  rt value (multiplier or divisor).
- `o_busy`  out  1  operation in flight.
- `o_done`  out  1  one-cycle pulse when HI/LO receive a new result.
- `o_stall`  out  1  combinational; the current EX instruction must be held.
- `o_hi`, `o_lo`  out  DATA_WIDTH  architectural HI/LO.
- `o_mf_data`  out  DATA_WIDTH  combinational: HI when funct is MFHI, otherwise LO.

## Operation
- Function codes:
  - MFHI = 010000, MTHI = 010001, MFLO = 010010, MTLO = 010011.
  - MULT = 011000, MULTU = 011001, DIV = 011010, DIVU = 011011.
  - All other codes: ignored, no state change.
- FSM states: IDLE, RUN, FIX.
- IDLE with `i_start` and a MULT, MULTU, DIV or DIVU code:
  - Latch the op type.
  - For signed ops, latch operand magnitudes plus both sign bits; for unsigned ops, latch operands raw.
  - Load iteration counter = DATA_WIDTH−1; go to RUN.
- IDLE with `i_start` and MTHI or MTLO: HI (or LO) ← `i_operand_a` at that edge. No busy, no `o_done`.
- RUN, multiply: one shift-add step per cycle into a 2·DATA_WIDTH accumulator.
- RUN, divide: one restoring step per cycle (shift remainder, trial subtract, set quotient bit).
- RUN exit: on the edge where counter = 0, go to FIX.
- FIX (one cycle):
  - Signed multiply: negate the product if the operand signs differ.
  - Signed divide: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Then {HI, LO} ← product, or HI ← remainder and LO ← quotient.
  - `o_done` ← 1 for one cycle; go to IDLE.
- Divide by zero: same latency; LO ← all ones, HI ← dividend (original signed value for DIV).
- Signed overflow (DIV of most-negative by −1): LO ← most-negative, HI ← 0. No trap.
- `o_busy` = (state ≠ IDLE), registered.
- `o_stall` = `i_start` & `o_busy` & (funct ∈ {MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV, DIVU}).
- While busy, `i_start` is ignored; HI/LO hold their old values until FIX.
- Reset (asynchronous, any state): state IDLE; HI = LO = 0; counter and accumulators = 0. The in-flight operation is discarded.
- Reset values of outputs: `o_busy` = 0, `o_done` = 0, `o_stall` = 0, `o_hi` = `o_lo` = 0, `o_mf_data` = 0.

## Timing
- Start is accepted at edge E0.
- RUN iterations occur at edges E1..E(DATA_WIDTH).
- HI/LO update at E(DATA_WIDTH+1), and `o_done` is high in the cycle after that edge. Latency is 33 edges for DATA_WIDTH = 32.
- `o_busy` is high from after E0 through E(DATA_WIDTH+1).
- A new start can be accepted in the same cycle `o_done` is high: back-to-back issue with zero bubble.
- An MFHI/MFLO issued in the `o_done` cycle reads the new value, with no stall.
- MTHI/MTLO: HI/LO updated at E0; a following MFHI/MFLO sees it next cycle.
- `o_mf_data` and `o_stall` are combinational from inputs and registers; they are not on a register-to-register path through the datapath.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. `o_done` exactly one cycle after E33; `o_busy` high for 33 cycles.
- MULT −3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. Then DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF, issued back-to-back in the `o_done` cycle. Also DIVU 7 / 2 → LO = 3, HI = 1.
- DIVU 5 / 0 → LO = 0xFFFFFFFF, HI = 5. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0. Both with normal latency.
- MFLO asserted while busy → `o_stall` = 1 each cycle, old LO on `o_mf_data`, MULT start ignored. In the `o_done` cycle → `o_stall` = 0, new LO presented.
- MTHI 0x12345678 then MFHI next cycle → `o_mf_data` = 0x12345678, `o_busy` stays 0, no `o_done`.
- Assert `i_rst_n` = 0 mid-MULT (at E10) → `o_busy`, `o_done`, HI and LO go to 0 immediately without a clock. After release, a fresh DIVU 100 / 7 gives LO = 14, HI = 2.
